// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Purpose : Constants shared between the instruction decoder and the
//           load/store unit. The load/store size codes are the RISC-V funct3
//           encodings of the LOAD/STORE opcodes.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

endpackage : riscv_pkg

// File: rtl/lsu_data_align.sv
// ----------------------------------------------------------------------------
// lsu_data_align
// Purpose : Purely combinational data steering for the load/store unit.
//           Store side: byte enables and lane-replicated write data for a
//           request. Load side: lane selection and sign/zero extension of the
//           bus read word.
// Ports   :
//   i_st_size [2:0]  size code of the request being accepted
//   i_st_off  [1:0]  byte offset of the request being accepted
//   i_st_wd   [31:0] right-aligned store data
//   o_be      [3:0]  byte enables, bit n = lane n
//   o_wd      [31:0] lane-replicated write data
//   i_ld_size [2:0]  size code of the outstanding request
//   i_ld_off  [1:0]  byte offset of the outstanding request
//   i_ld_rd   [31:0] bus read word
//   o_ld_data [31:0] extended load result
// ----------------------------------------------------------------------------
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wd,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd,
    input  logic [2:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_rd,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side. Unused size codes (3/6/7) fall through to a full word.
    // Unsigned codes are not meaningful for stores; they steer like their
    // signed counterparts so the lanes are still self-consistent.
    always_comb begin
        o_be = 4'b1111;
        o_wd = i_st_wd;
        case (i_st_size)
            LDST_B, LDST_BU: begin
                o_be = 4'b0001 << i_st_off;
                o_wd = {4{i_st_wd[7:0]}};
            end
            LDST_H, LDST_HU: begin
                // addr[0] is ignored: halves always sit on lanes 0-1 or 2-3
                o_be = 4'b0011 << {i_st_off[1], 1'b0};
                o_wd = {2{i_st_wd[15:0]}};
            end
            default: begin
                o_be = 4'b1111;
                o_wd = i_st_wd;
            end
        endcase
    end

    // Load side lane selection.
    always_comb begin
        w_byte = i_ld_rd[7:0];
        case (i_ld_off)
            2'd0:    w_byte = i_ld_rd[7:0];
            2'd1:    w_byte = i_ld_rd[15:8];
            2'd2:    w_byte = i_ld_rd[23:16];
            default: w_byte = i_ld_rd[31:24];
        endcase
        w_half = i_ld_off[1] ? i_ld_rd[31:16] : i_ld_rd[15:0];
    end

    // Load side extension.
    always_comb begin
        o_ld_data = i_ld_rd;
        case (i_ld_size)
            LDST_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_ld_data = {24'd0, w_byte};
            LDST_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_rd;
        endcase
    end

endmodule : lsu_data_align

// File: rtl/riscv_lsu.sv
// ----------------------------------------------------------------------------
// riscv_lsu
// Purpose : Load/store unit between the core data port and the data bus.
//           Accepts one core request, issues one word-aligned bus transaction
//           with byte enables, waits for mem_ready_i, and returns the
//           extended load data. The core is stalled for the whole access.
// Ports   :
//   clk_i, rst_i           clock, asynchronous active-high reset
//   core_req_i/we/size/addr/wd   core request (held by the core while stalled)
//   core_rd_o   [31:0]     extended load result, valid in DONE
//   core_stall_o           hold core (combinational)
//   mem_req_o/we/be/addr/wd     bus request, stable for the whole transaction
//   mem_rd_i    [31:0]     bus read word
//   mem_ready_i            bus completes the current request this cycle
//   dbg_state_o [1:0]      FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: the bus transfer happens on the rising edge where mem_req_o and
// mem_ready_i are both high. mem_req_o stays high and every mem_* output
// stays constant until that edge; mem_ready_i is ignored while mem_req_o is
// low. On the core side, the access retires on the edge where core_stall_o
// is low in DONE; core_req_i is not sampled in DONE.
// ----------------------------------------------------------------------------
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_finish;

    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [29:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;
    logic [31:0] r_rd;

    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_ld_data;

    // Store steering is computed from the incoming request and registered, so
    // the bus outputs read as zero out of reset; extraction uses the latched
    // request since the core inputs are not looked at after acceptance.
    lsu_data_align u_align (
        .i_st_size (core_size_i),
        .i_st_off  (core_addr_i[1:0]),
        .i_st_wd   (core_wd_i),
        .o_be      (w_be),
        .o_wd      (w_wd),
        .i_ld_size (r_size),
        .i_ld_off  (r_off),
        .i_ld_rd   (mem_rd_i),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_req_i) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready_i) begin
                    w_finish = 1'b1;
                    w_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                // core_req_i still belongs to the retiring instruction
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we   <= 1'b0;
            r_size <= 3'd0;
            r_off  <= 2'd0;
            r_addr <= 30'd0;
            r_be   <= 4'd0;
            r_wd   <= 32'd0;
        end else if (w_accept) begin
            r_we   <= core_we_i;
            r_size <= core_size_i;
            r_off  <= core_addr_i[1:0];
            r_addr <= core_addr_i[31:2];
            r_be   <= w_be;
            r_wd   <= w_wd;
        end
    end

    // Stores leave the previous load result in place.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd <= 32'd0;
        end else if (w_finish && !r_we) begin
            r_rd <= w_ld_data;
        end
    end

    assign core_rd_o    = r_rd;
    assign core_stall_o = ((r_state == ST_IDLE) && core_req_i) || (r_state == ST_BUSY);
    assign mem_req_o    = (r_state == ST_BUSY);
    assign mem_we_o     = r_we;
    assign mem_be_o     = r_be;
    assign mem_addr_o   = {r_addr, 2'b00};
    assign mem_wd_o     = r_wd;
    assign dbg_state_o  = r_state;

endmodule : riscv_lsu

// File: tb/tb_riscv_lsu.sv
// ----------------------------------------------------------------------------
// tb_riscv_lsu
// Purpose : Directed self-checking bench for riscv_lsu. Inputs are driven and
//           outputs sampled 1-2 time units after the rising clock edge.
// ----------------------------------------------------------------------------
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i),
        .dbg_state_o  (dbg_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access. ready arrives in BUSY cycle 'delay' (>=1).
    // With hold, mem_ready_i is high from the request cycle onward.
    task automatic access(input string tag, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input logic hold,
                          input logic [31:0] exp_rd, input logic [31:0] exp_be,
                          input logic [31:0] exp_wd);
        int stalls;
        stalls      = 0;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rdata;
        if (hold) mem_ready_i = 1'b1;
        #1;
        chk({tag, ".idle_state"}, {30'd0, dbg_state_o}, 32'd0);
        if (core_stall_o) stalls++;
        tick();
        for (int c = 1; c <= delay; c++) begin
            // Scramble the core side: the bus must run from latched values.
            core_addr_i = $urandom;
            core_wd_i   = $urandom;
            core_size_i = 3'($urandom_range(0, 7));
            core_we_i   = ~we;
            if (c == delay) mem_ready_i = 1'b1;
            #1;
            chk({tag, ".busy_state"}, {30'd0, dbg_state_o}, 32'd1);
            chk({tag, ".mem_req"}, {31'd0, mem_req_o}, 32'd1);
            chk({tag, ".mem_we"}, {31'd0, mem_we_o}, {31'd0, we});
            chk({tag, ".mem_be"}, {28'd0, mem_be_o}, exp_be);
            chk({tag, ".mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
            chk({tag, ".mem_wd"}, mem_wd_o, exp_wd);
            if (core_stall_o) stalls++;
            tick();
        end
        if (!hold) mem_ready_i = 1'b0;
        mem_rd_i = $urandom;
        #1;
        chk({tag, ".done_state"}, {30'd0, dbg_state_o}, 32'd2);
        chk({tag, ".done_stall"}, {31'd0, core_stall_o}, 32'd0);
        chk({tag, ".core_rd"}, core_rd_o, exp_rd);
        chk({tag, ".stall_cycles"}, stalls, delay + 1);
        core_req_i = 1'b0;
        tick();
        chk({tag, ".back_idle"}, {30'd0, dbg_state_o}, 32'd0);
        chk({tag, ".idle_req"}, {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'd0;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'd0;
        mem_ready_i = 1'b0;
        #2;
        chk("rst.state", {30'd0, dbg_state_o}, 32'd0);
        chk("rst.mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst.mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst.mem_be", {28'd0, mem_be_o}, 32'd0);
        chk("rst.mem_addr", mem_addr_o, 32'd0);
        chk("rst.mem_wd", mem_wd_o, 32'd0);
        chk("rst.core_rd", core_rd_o, 32'd0);
        chk("rst.stall_lo", {31'd0, core_stall_o}, 32'd0);
        core_req_i = 1'b1;
        #1;
        chk("rst.stall_hi", {31'd0, core_stall_o}, 32'd1);
        core_req_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // mem_ready_i outside BUSY is ignored
        mem_ready_i = 1'b1;
        tick();
        chk("stray_ready.state", {30'd0, dbg_state_o}, 32'd0);
        chk("stray_ready.mem_req", {31'd0, mem_req_o}, 32'd0);
        mem_ready_i = 1'b0;

        //       tag    we    size  addr          wd            rdata         dly hold exp_rd        be      wd
        access("lw",   1'b0, 3'd2, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 32'hF, 32'h0000_0000);
        access("lb",   1'b0, 3'd0, 32'h0000_0103, 32'h0000_0000, 32'h8011_2233, 1, 1'b0, 32'hFFFF_FF80, 32'h8, 32'h0000_0000);
        access("lbu",  1'b0, 3'd4, 32'h0000_0103, 32'h0000_005A, 32'h8011_2233, 1, 1'b0, 32'h0000_0080, 32'h8, 32'h5A5A_5A5A);
        access("lh",   1'b0, 3'd1, 32'h0000_0102, 32'h0000_0000, 32'h9ABC_0000, 1, 1'b0, 32'hFFFF_9ABC, 32'hC, 32'h0000_0000);
        access("lhu",  1'b0, 3'd5, 32'h0000_0102, 32'h0000_0000, 32'h9ABC_0000, 1, 1'b0, 32'h0000_9ABC, 32'hC, 32'h0000_0000);
        access("sb",   1'b1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1'b0, 32'h0000_9ABC, 32'h2, 32'hA5A5_A5A5);
        access("sh",   1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 32'hFFFF_FFFF, 5, 1'b0, 32'h0000_9ABC, 32'hC, 32'h1234_1234);
        access("lh_mis", 1'b0, 3'd1, 32'h0000_0103, 32'h0000_0000, 32'h7FFF_1234, 2, 1'b0, 32'h0000_7FFF, 32'hC, 32'h0000_0000);
        access("lw_mis", 1'b0, 3'd2, 32'h0000_0101, 32'h0000_0000, 32'h1122_3344, 1, 1'b0, 32'h1122_3344, 32'hF, 32'h0000_0000);
        access("lb_hold", 1'b0, 3'd0, 32'h0000_0100, 32'h0000_0000, 32'h0000_00FF, 1, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
        access("sz3_hold", 1'b0, 3'd3, 32'h0000_0106, 32'h0000_0000, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D, 32'hF, 32'h0000_0000);
        mem_ready_i = 1'b0;

        // Reset in the second BUSY cycle of a load
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_0300;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'h1111_1111;
        tick();
        chk("rstmid.busy1_req", {31'd0, mem_req_o}, 32'd1);
        tick();
        chk("rstmid.busy2_state", {30'd0, dbg_state_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstmid.mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rstmid.state", {30'd0, dbg_state_o}, 32'd0);
        chk("rstmid.core_rd", core_rd_o, 32'd0);
        chk("rstmid.mem_be", {28'd0, mem_be_o}, 32'd0);
        chk("rstmid.mem_addr", mem_addr_o, 32'd0);
        core_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        access("lw_after_rst", 1'b0, 3'd2, 32'h0000_0400, 32'h0000_0000, 32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D, 32'hF, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_riscv_lsu
